// File: rtl/bcd_scan_if.sv
// bcd_scan_if: load/status/scan bundle between a value source and bcd_scan.
// Ports: din/din_valid (source -> scanner); busy, dout, sel, blank (scanner -> source/display).
// master = value source and display consumer, slave = bcd_scan itself.
interface bcd_scan_if;
   logic [15:0] din;       // unsigned binary value to display
   logic        din_valid; // load strobe, honoured only while idle
   logic        busy;      // conversion in progress
   logic [3:0]  dout;      // BCD code of the selected digit
   logic [4:0]  sel;       // one-hot digit enable, bit 0 = units
   logic        blank;     // selected digit is a suppressed leading zero

   modport master (
      output din, din_valid,
      input  busy, dout, sel, blank
   );

   modport slave (
      input  din, din_valid,
      output busy, dout, sel, blank
   );
endinterface

// File: rtl/bcd_scan.sv
// bcd_scan: 16-bit binary to 5-digit BCD (double-dabble) with a multiplexed 7-segment digit scanner.
// Latency: load at edge t, 16 conversion cycles, new digits visible from edge t+17; scan runs every SCAN_DIV cycles.
// Backpressure: none; din_valid while busy is dropped. Ports: clk, rst (sync, active-high), bus (bcd_scan_if.slave).
module bcd_scan #(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst,
   bcd_scan_if.slave  bus
);

   typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

   localparam logic [19:0] PRESC_LAST = 20'(SCAN_DIV - 1);

   state_t      state;
   state_t      state_nxt;
   logic [15:0] shreg;
   logic [19:0] work;
   logic [19:0] work_adj;
   logic [19:0] work_shift;
   logic [4:0]  cnt;
   logic [19:0] disp;
   logic [19:0] presc;
   logic [2:0]  idx;
   logic        last_shift;

   assign last_shift = (cnt == 5'd15);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.din_valid) state_nxt = CONV;
         CONV:    if (last_shift)    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      bus.busy = (state == CONV);
   end

   // Double-dabble step: correct every nibble >= 5 before the shift so that
   // the doubling carries correctly into the next decimal digit.
   always_comb begin
      work_adj = work;
      for (int i = 0; i < 5; i++) begin
         if (work[4*i +: 4] >= 4'd5) begin
            work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
         end
      end
      work_shift = {work_adj[18:0], shreg[15]};
   end

   // Conversion datapath. The display register is only written on the final
   // shift, so the scanner never sees a partial result.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg <= '0;
         work  <= '0;
         cnt   <= '0;
         disp  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.din_valid) begin
                  shreg <= bus.din;
                  work  <= '0;
                  cnt   <= '0;
               end
            end
            CONV: begin
               shreg <= {shreg[14:0], 1'b0};
               work  <= work_shift;
               cnt   <= cnt + 5'd1;
               if (last_shift) begin
                  disp <= work_shift;
               end
            end
            default: ;
         endcase
      end
   end

   // Free-running scan prescaler and digit index, independent of the FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
         idx   <= '0;
      end else if (presc == PRESC_LAST) begin
         presc <= '0;
         idx   <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
      end else begin
         presc <= presc + 20'd1;
      end
   end

   // Digit decode from registered idx/disp only. Blank is set when this digit
   // and every digit above it are zero; the units digit is never blanked.
   always_comb begin
      bus.sel   = 5'b00001;
      bus.dout  = disp[3:0];
      bus.blank = 1'b0;
      case (idx)
         3'd1: begin
            bus.sel   = 5'b00010;
            bus.dout  = disp[7:4];
            bus.blank = (disp[19:4] == 16'd0);
         end
         3'd2: begin
            bus.sel   = 5'b00100;
            bus.dout  = disp[11:8];
            bus.blank = (disp[19:8] == 12'd0);
         end
         3'd3: begin
            bus.sel   = 5'b01000;
            bus.dout  = disp[15:12];
            bus.blank = (disp[19:12] == 8'd0);
         end
         3'd4: begin
            bus.sel   = 5'b10000;
            bus.dout  = disp[19:16];
            bus.blank = (disp[19:16] == 4'd0);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bcd_scan.sv
// tb_bcd_scan: directed checks of bcd_scan with SCAN_DIV=1 (dut1) and SCAN_DIV=4 (dut4).
// Inputs driven 1ns after the rising edge; outputs sampled at the same point.
// Ends with a single summary line.
module tb_bcd_scan;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   bcd_scan_if if1 ();
   bcd_scan_if if4 ();

   bcd_scan #(.SCAN_DIV(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1.slave)
   );

   bcd_scan #(.SCAN_DIV(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (if4.slave)
   );

   int tests = 0;
   int fails = 0;

   int dig  [5];
   int bl   [5];
   bit seen [5];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One load pulse on dut1; returns 1ns after the edge that sampled it.
   task automatic pulse(input logic [15:0] v);
      if1.din       = v;
      if1.din_valid = 1'b1;
      step();
      if1.din_valid = 1'b0;
   endtask

   // Capture the five scanned digits of dut1 over five cycles.
   task automatic read_digits();
      for (int k = 0; k < 5; k++) begin
         seen[k] = 1'b0;
         dig[k]  = -1;
         bl[k]   = -1;
      end
      for (int k = 0; k < 5; k++) begin
         int i;
         case (if1.sel)
            5'b00001: i = 0;
            5'b00010: i = 1;
            5'b00100: i = 2;
            5'b01000: i = 3;
            5'b10000: i = 4;
            default:  i = -1;
         endcase
         if (i >= 0) begin
            dig[i]  = int'(if1.dout);
            bl[i]   = int'(if1.blank);
            seen[i] = 1'b1;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      if1.din       = 16'd1234;
      if1.din_valid = 1'b1;   // reset must win over the load strobe
      step();
      step();
      tests++; if (if1.sel !== 5'b00001) begin fails++; $display("FAIL reset_sel1: got %b exp 00001", if1.sel); end
      tests++; if (if1.dout !== 4'd0) begin fails++; $display("FAIL reset_dout1: got %0d exp 0", if1.dout); end
      tests++; if (if1.blank !== 1'b0) begin fails++; $display("FAIL reset_blank1: got %b exp 0", if1.blank); end
      tests++; if (if1.busy !== 1'b0) begin fails++; $display("FAIL reset_busy1: got %b exp 0", if1.busy); end
      tests++; if (if4.sel !== 5'b00001) begin fails++; $display("FAIL reset_sel4: got %b exp 00001", if4.sel); end
      tests++; if (if4.dout !== 4'd0) begin fails++; $display("FAIL reset_dout4: got %0d exp 0", if4.dout); end
      tests++; if (if4.blank !== 1'b0) begin fails++; $display("FAIL reset_blank4: got %b exp 0", if4.blank); end
      tests++; if (if4.busy !== 1'b0) begin fails++; $display("FAIL reset_busy4: got %b exp 0", if4.busy); end
      rst           = 1'b0;
      if1.din_valid = 1'b0;
      step();
      tests++; if (if1.busy !== 1'b0) begin fails++; $display("FAIL reset_prio_busy: got %b exp 0", if1.busy); end
   endtask

   task automatic test_max();
      int n;
      int exp_d [5];
      exp_d = '{5, 3, 5, 5, 6};
      pulse(16'd65535);
      n = 0;
      for (int k = 0; k < 40; k++) begin
         if (if1.busy === 1'b1) n++;
         step();
      end
      tests++; if (n != 16) begin fails++; $display("FAIL max_busy_cycles: got %0d exp 16", n); end
      read_digits();
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (!seen[i] || dig[i] != exp_d[i] || bl[i] != 0) begin
            fails++;
            $display("FAIL max_digit%0d: got seen=%0d dout=%0d blank=%0d exp dout=%0d blank=0", i, seen[i], dig[i], bl[i], exp_d[i]);
         end
      end
   endtask

   task automatic test_drop();
      int exp_d [5];
      exp_d = '{5, 4, 3, 2, 1};
      pulse(16'd12345);                 // sampled at edge t
      repeat (4) step();
      if1.din       = 16'd7;
      if1.din_valid = 1'b1;             // sampled at edge t+5 (busy cycle 5)
      step();
      if1.din_valid = 1'b0;
      tests++; if (if1.busy !== 1'b1) begin fails++; $display("FAIL drop_busy_mid: got %b exp 1", if1.busy); end
      repeat (10) step();
      if1.din_valid = 1'b1;             // sampled at edge t+16 (busy cycle 16)
      tests++; if (if1.busy !== 1'b1) begin fails++; $display("FAIL drop_busy_last: got %b exp 1", if1.busy); end
      step();
      if1.din_valid = 1'b0;
      tests++; if (if1.busy !== 1'b0) begin fails++; $display("FAIL drop_busy_end: got %b exp 0", if1.busy); end
      step();
      tests++; if (if1.busy !== 1'b0) begin fails++; $display("FAIL drop_no_queue: got %b exp 0", if1.busy); end
      repeat (20) step();
      read_digits();
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (!seen[i] || dig[i] != exp_d[i] || bl[i] != 0) begin
            fails++;
            $display("FAIL drop_digit%0d: got seen=%0d dout=%0d blank=%0d exp dout=%0d blank=0", i, seen[i], dig[i], bl[i], exp_d[i]);
         end
      end
   endtask

   task automatic test_blank();
      logic [15:0] vals [3];
      int exp_d [3][5];
      int exp_b [3][5];
      vals  = '{16'd7, 16'd0, 16'd1005};
      exp_d = '{'{7, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}, '{5, 0, 0, 1, 0}};
      exp_b = '{'{0, 1, 1, 1, 1}, '{0, 1, 1, 1, 1}, '{0, 0, 0, 0, 1}};
      for (int v = 0; v < 3; v++) begin
         pulse(vals[v]);
         repeat (20) step();
         read_digits();
         for (int i = 0; i < 5; i++) begin
            tests++;
            if (!seen[i] || dig[i] != exp_d[v][i] || bl[i] != exp_b[v][i]) begin
               fails++;
               $display("FAIL blank_%0d_digit%0d: got seen=%0d dout=%0d blank=%0d exp dout=%0d blank=%0d",
                        vals[v], i, seen[i], dig[i], bl[i], exp_d[v][i], exp_b[v][i]);
            end
         end
      end
   endtask

   task automatic test_scan();
      logic [4:0] exp_sel;
      logic [4:0] one;
      one = 5'b00001;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < 24; k++) begin
         exp_sel = one << ((k / 4) % 5);
         tests++;
         if (if4.sel !== exp_sel) begin
            fails++;
            $display("FAIL scan4_sel_cycle%0d: got %b exp %b", k, if4.sel, exp_sel);
         end
         step();
      end
   endtask

   task automatic test_abort();
      int exp_n [5];
      int exp_z [5];
      exp_n = '{9, 9, 9, 0, 0};
      exp_z = '{0, 1, 1, 1, 1};
      pulse(16'd42);
      repeat (20) step();
      read_digits();
      tests++; if (dig[0] != 2 || dig[1] != 4) begin fails++; $display("FAIL abort_pre42: got %0d%0d exp 42", dig[1], dig[0]); end
      pulse(16'd999);                   // sampled at edge t
      repeat (7) step();
      rst = 1'b1;                       // sampled at edge t+8 (busy cycle 8)
      step();
      rst = 1'b0;
      tests++; if (if1.busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b exp 0", if1.busy); end
      tests++; if (if1.dout !== 4'd0) begin fails++; $display("FAIL abort_dout: got %0d exp 0", if1.dout); end
      tests++; if (if1.sel !== 5'b00001) begin fails++; $display("FAIL abort_sel: got %b exp 00001", if1.sel); end
      read_digits();
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (!seen[i] || dig[i] != 0 || bl[i] != exp_z[i]) begin
            fails++;
            $display("FAIL abort_zero_digit%0d: got seen=%0d dout=%0d blank=%0d exp dout=0 blank=%0d", i, seen[i], dig[i], bl[i], exp_z[i]);
         end
      end
      pulse(16'd999);                   // sampled at edge t'
      repeat (15) step();               // just after edge t'+15: old display still shown
      tests++; if (if1.busy !== 1'b1) begin fails++; $display("FAIL lat_busy15: got %b exp 1", if1.busy); end
      tests++; if (if1.dout !== 4'd0) begin fails++; $display("FAIL lat_old_dout: got %0d exp 0", if1.dout); end
      step();                           // just after edge t'+16: sampled as new from edge t'+17
      tests++; if (if1.busy !== 1'b0) begin fails++; $display("FAIL lat_busy16: got %b exp 0", if1.busy); end
      read_digits();
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (!seen[i] || dig[i] != exp_n[i]) begin
            fails++;
            $display("FAIL lat_999_digit%0d: got seen=%0d dout=%0d exp %0d", i, seen[i], dig[i], exp_n[i]);
         end
      end
   endtask

   initial begin
      rst           = 1'b1;
      if1.din       = '0;
      if1.din_valid = 1'b0;
      if4.din       = '0;
      if4.din_valid = 1'b0;
      test_reset();
      test_max();
      test_drop();
      test_blank();
      test_scan();
      test_abort();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", tests, fails);
      $fatal(1);
   end

endmodule

// File: doc/bcd_scan.md
BCD_SCAN -- requirements
Module: bcd_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clock cycles each digit is displayed; legal range 1..2^20.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port DIN  input  16  unsigned binary value to display.
REQ-005 SHALL have port DIN_VALID  input  1  load strobe; DIN sampled when high and block idle.
REQ-006 SHALL have port BUSY  output  1  high while a conversion is in progress.
REQ-007 SHALL have port DOUT  output  4  BCD code of the currently selected digit, feeding the 7-segment encoder.
REQ-008 SHALL have port SEL  output  5  one-hot digit enable, active high; bit 0 = units digit.
REQ-009 SHALL have port BLANK  output  1  high when the currently selected digit is a suppressed leading zero.

Function
REQ-010 SHALL implement a two-state FSM: IDLE and CONV.
REQ-011 In IDLE with DIN_VALID=1, SHALL capture DIN into a 16-bit shift register, clear a 20-bit BCD work register and a 5-bit shift counter, and enter CONV.
REQ-012 In IDLE with DIN_VALID=0, SHALL remain in IDLE with no state change except scanning.
REQ-013 In each CONV cycle, SHALL first add 3 to every work-register nibble >= 5, then shift the work register left one bit, taking the shift register MSB into bit 0 and shifting the shift register left.
REQ-014 SHALL perform exactly 16 CONV cycles; after the 16th shift, SHALL copy the work register into the 20-bit display register and return to IDLE.
REQ-015 Latency: DIN_VALID sampled at edge t SHALL make the new display register visible from edge t+17.
REQ-016 BUSY SHALL be 1 exactly in CONV cycles, i.e. 16 cycles per conversion.
REQ-017 DIN_VALID in any CONV cycle, including the last, SHALL be ignored and the request dropped; no queueing.
REQ-018 The display register SHALL hold its previous value throughout a conversion; partial results SHALL never appear on DOUT.
REQ-019 SHALL have a prescaler counting 0..SCAN_DIV-1 that wraps to 0; at terminal count, the digit index SHALL advance 0,1,2,3,4,0,...
REQ-020 With SCAN_DIV=1, the digit index SHALL advance every cycle.
REQ-021 Scanning SHALL run continuously and independently of the FSM state.
REQ-022 SEL SHALL be the one-hot decode of the digit index; DOUT SHALL be display nibble [4*idx+3:4*idx]; both SHALL be registered or decoded from registered state, with no combinational path from DIN.
REQ-023 BLANK SHALL be 1 when the selected digit and all more-significant digits are 0 and idx != 0; the units digit SHALL never be blanked.
REQ-024 DOUT SHALL always be a legal BCD value (0..9) after reset.

Reset
REQ-025 RST=1 SHALL force state IDLE, BUSY=0, display register 0, work register 0, prescaler 0, digit index 0, SEL=5'b00001, DOUT=0, BLANK=0.
REQ-026 RST asserted mid-conversion SHALL abort the conversion; the display SHALL read 0 and BUSY SHALL be 0 on the cycle after.
REQ-027 RST SHALL take priority over DIN_VALID in the same cycle.

Verification
REQ-028 Reset only -> SEL=00001, DOUT=0, BLANK=0, BUSY=0.
REQ-029 SCAN_DIV=1, DIN=65535 pulsed -> BUSY high 16 cycles; afterwards digits 4..0 = 6,5,5,3,5, all with BLANK=0.
REQ-030 DIN=12345 pulsed, then DIN=7 pulsed at BUSY cycle 5 and at BUSY cycle 16 -> display 1,2,3,4,5; the 7 never appears.
REQ-031 DIN=7 -> idx0 DOUT=7, BLANK=0; idx1..4 DOUT=0, BLANK=1. DIN=0 -> idx0 DOUT=0, BLANK=0; others BLANK=1. DIN=1005 -> idx2 DOUT=0, BLANK=0.
REQ-032 SCAN_DIV=4 -> SEL changes every 4 cycles in the order 00001,00010,00100,01000,10000,00001.
REQ-033 Display 42, then DIN=999 pulsed, RST at BUSY cycle 8 -> next cycle BUSY=0 and all digits 0; a following DIN=999 pulse displays 9,9,9 after 17 cycles.
